// File: rtl/dac_pkg.sv
// Shared constants and types for the PWM / sigma-delta audio output stage.
package dac_pkg;
    localparam int SAMPLE_W         = 16;
    localparam int PWM_BITS_DEFAULT = 8;

    localparam logic DAC_MODE_PWM = 1'b0;
    localparam logic DAC_MODE_SD  = 1'b1;

    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sd_mod1.sv
// First-order sigma-delta modulator: 16-bit wrap-around accumulator whose carry is the output bit.
module sd_mod1
    import dac_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] x,
    output logic                y
);

    logic [SAMPLE_W-1:0] acc_reg;
    logic                y_reg;
    logic [SAMPLE_W:0]   sum_next;

    // The carry of each sum is the pulse; only the low 16 bits carry over.
    assign sum_next = {1'b0, acc_reg} + {1'b0, x};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            y_reg   <= 1'b0;
        end else if (en) begin
            acc_reg <= sum_next[SAMPLE_W-1:0];
            y_reg   <= sum_next[SAMPLE_W];
        end
    end

    assign y = y_reg;

endmodule

// File: rtl/pwm_dac.sv
// Audio DAC output stage: double-buffered sample input, period counter, PWM compare,
// sigma-delta sub-modulator, sticky overrun/underrun flags and the output mux.
module pwm_dac
    import dac_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] din,
    input  logic                din_valid,
    input  logic                mode,
    input  logic                flag_clr,
    output logic                sample_req,
    output logic                dout,
    output logic                overrun,
    output logic                underrun
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] cnt_reg;
    sample_t             active_reg, active_next;
    sample_t             pend_reg, pend_next;
    logic                pend_full_reg, pend_full_next;
    logic                mode_q_reg, mode_q_next;
    logic                overrun_reg, overrun_next;
    logic                underrun_reg, underrun_next;
    logic                pwm_reg;
    logic                sel_reg;
    logic                req_reg;
    logic                boundary;
    logic [PWM_BITS-1:0] duty;
    logic                sd_y;

    assign boundary = (cnt_reg == CNT_MAX);
    assign duty     = active_reg[SAMPLE_W-1 -: PWM_BITS];

    always_comb begin
        active_next    = active_reg;
        pend_next      = pend_reg;
        pend_full_next = pend_full_reg;
        mode_q_next    = mode_q_reg;
        overrun_next   = overrun_reg;
        underrun_next  = underrun_reg;

        if (boundary) begin
            mode_q_next = mode;
            if (pend_full_reg) begin
                active_next    = pend_reg;
                pend_full_next = din_valid;
                if (din_valid) begin
                    pend_next = din;
                end
            end else if (din_valid) begin
                active_next = din;
            end else begin
                underrun_next = 1'b1;
            end
        end else if (din_valid) begin
            pend_next      = din;
            pend_full_next = 1'b1;
            if (pend_full_reg) begin
                overrun_next = 1'b1;
            end
        end

        if (flag_clr) begin
            overrun_next  = 1'b0;
            underrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            active_reg    <= '0;
            pend_reg      <= '0;
            pend_full_reg <= 1'b0;
            mode_q_reg    <= DAC_MODE_PWM;
            overrun_reg   <= 1'b0;
            underrun_reg  <= 1'b0;
            pwm_reg       <= 1'b0;
            sel_reg       <= DAC_MODE_PWM;
            // Primed so the first cnt == 0 cycle after release also requests a sample.
            req_reg       <= 1'b1;
        end else begin
            cnt_reg       <= cnt_reg + 1'b1;
            active_reg    <= active_next;
            pend_reg      <= pend_next;
            pend_full_reg <= pend_full_next;
            mode_q_reg    <= mode_q_next;
            overrun_reg   <= overrun_next;
            underrun_reg  <= underrun_next;
            pwm_reg       <= (cnt_reg < duty);
            sel_reg       <= mode_q_reg;
            req_reg       <= boundary;
        end
    end

    sd_mod1 u_sd (
        .clk (clk),
        .rst (rst),
        .en  (mode_q_reg == DAC_MODE_SD),
        .x   (active_reg),
        .y   (sd_y)
    );

    // sel_reg is aligned with both modulator registers, so the mux output is glitch-free.
    assign dout       = (sel_reg == DAC_MODE_SD) ? sd_y : pwm_reg;
    assign sample_req = req_reg & ~rst;
    assign overrun    = overrun_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_pwm_dac.sv
// Randomized and directed bench for pwm_dac against a time/queue-based reference model.
module tb_pwm_dac;
    localparam int B = 8;
    localparam int P = 1 << B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        mode = 1'b0;
    logic        flag_clr = 1'b0;
    logic        sample_req, dout, overrun, underrun;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed cycles since reset, held sample, FIFO of at most one waiting sample.
    int m_t = 0;
    int m_act = 0;
    int m_q[$];
    int m_mode = 0;
    int m_acc = 0;
    int e_dout = 0;
    int e_ov = 0;
    int e_un = 0;

    pwm_dac #(.PWM_BITS(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .mode       (mode),
        .flag_clr   (flag_clr),
        .sample_req (sample_req),
        .dout       (dout),
        .overrun    (overrun),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, m_t);
        end
    endtask

    task automatic model_edge();
        int ph;
        int s;
        bit bnd;
        bit ov_set;
        bit un_set;
        if (rst) begin
            m_t = 0; m_act = 0; m_q.delete(); m_mode = 0; m_acc = 0;
            e_dout = 0; e_ov = 0; e_un = 0;
        end else begin
            ph  = m_t % P;
            bnd = (ph == P - 1);
            if (m_mode != 0) begin
                s      = m_acc + m_act;
                e_dout = (s >= 65536) ? 1 : 0;
                m_acc  = s % 65536;
            end else begin
                e_dout = (ph < (m_act >> (16 - B))) ? 1 : 0;
            end
            ov_set = din_valid && (m_q.size() > 0) && !bnd;
            un_set = bnd && (m_q.size() == 0) && !din_valid;
            if (bnd) begin
                if (m_q.size() > 0) begin
                    m_act = m_q.pop_front();
                    if (din_valid) m_q.push_back(int'(din));
                end else if (din_valid) begin
                    m_act = int'(din);
                end
                m_mode = int'(mode);
            end else if (din_valid) begin
                m_q.delete();
                m_q.push_back(int'(din));
            end
            if (flag_clr) begin
                e_ov = 0; e_un = 0;
            end else begin
                if (ov_set) e_ov = 1;
                if (un_set) e_un = 1;
            end
            m_t++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("dout", int'(dout), e_dout);
        chk("sample_req", int'(sample_req), (!rst && (m_t % P == 0)) ? 1 : 0);
        chk("overrun", int'(overrun), e_ov);
        chk("underrun", int'(underrun), e_un);
    endtask

    task automatic strobe(input logic [15:0] d);
        $display("txn din=%h mode=%0d phase=%0d", d, mode, m_t % P);
        din = d;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < P + 2 && (m_t % P) != ph; i++) step();
        chk("phase_reach", m_t % P, ph);
    endtask

    task automatic count_window(output int ones);
        ones = int'(dout);
        repeat (P - 1) begin
            step();
            ones += int'(dout);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("req_after_rst", int'(sample_req), 1);
        chk("dout_after_rst", int'(dout), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ones;
        @(negedge clk);

        // Idle after reset: requests each period, underrun after first boundary.
        do_reset();
        run_to_phase(P - 1);
        chk("idle_no_underrun_yet", int'(underrun), 0);
        step();
        chk("idle_underrun", int'(underrun), 1);
        repeat (2 * P) step();

        // PWM quarter duty.
        do_reset();
        run_to_phase(10);
        strobe(16'h4000);
        run_to_phase(1);
        count_window(ones);
        chk("pwm_4000_ones", ones, 64);

        // PWM edge values.
        do_reset();
        run_to_phase(10);
        strobe(16'h0000);
        run_to_phase(1);
        count_window(ones);
        chk("pwm_0000_ones", ones, 0);
        run_to_phase(10);
        strobe(16'hFFFF);
        run_to_phase(1);
        count_window(ones);
        chk("pwm_ffff_ones", ones, 255);

        // Sigma-delta half scale.
        do_reset();
        mode = 1'b1;
        run_to_phase(10);
        strobe(16'h8000);
        run_to_phase(1);
        count_window(ones);
        chk("sd_8000_ones", ones, 128);
        mode = 1'b0;
        run_to_phase(1);

        // Overrun: two strobes in one period, newer wins.
        do_reset();
        run_to_phase(10);
        strobe(16'h1000);
        run_to_phase(20);
        strobe(16'h2000);
        chk("ovr_set", int'(overrun), 1);
        run_to_phase(1);
        count_window(ones);
        chk("ovr_newer_duty", ones, 32);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        // Strobe on the boundary while a sample is pending.
        do_reset();
        run_to_phase(10);
        strobe(16'h3000);
        run_to_phase(P - 1);
        strobe(16'h9000);
        chk("coinc_no_ovr", int'(overrun), 0);
        run_to_phase(1);
        count_window(ones);
        chk("coinc_old_duty", ones, 48);
        run_to_phase(1);
        count_window(ones);
        chk("coinc_new_duty", ones, 144);

        // Mid-period reset after flags have been set.
        do_reset();
        run_to_phase(10);
        strobe(16'h5000);
        run_to_phase(1);
        repeat (P + 99) step();
        chk("pre_rst_phase", m_t % P, 100);
        chk("pre_rst_underrun", int'(underrun), 1);
        rst = 1'b1;
        step();
        chk("rst_dout", int'(dout), 0);
        chk("rst_req", int'(sample_req), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        #1;
        chk("rst_restart_req", int'(sample_req), 1);
        repeat (P) step();

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 12000; i++) begin
            din_valid = ($urandom_range(0, 119) == 0);
            din       = 16'($urandom);
            if ($urandom_range(0, 499) == 0) mode = ~mode;
            flag_clr  = ($urandom_range(0, 299) == 0);
            rst       = ($urandom_range(0, 3999) == 0);
            if (din_valid) $display("txn din=%h mode=%0d phase=%0d", din, mode, m_t % P);
            step();
        end
        din_valid = 1'b0;
        flag_clr  = 1'b0;
        rst       = 1'b0;
        repeat (P) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
